// File: rtl/fu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fu_pkg
//  Purpose  : Shared constants, the issue-queue entry type and a readiness
//             helper used by the functional-unit issue queue.
//  Revision : 1.0 - initial release
// ============================================================================
package fu_pkg;

    localparam int NUM_OPS  = 3;   // source operands per instruction
    localparam int NUM_WB   = 3;   // writeback broadcast lanes
    localparam int IQ_PRN_W = 7;   // physical register tag width held in an entry
    localparam int IQ_ID_W  = 6;   // instruction id width held in an entry

    // One reservation-station slot; the valid bit lives beside it.
    typedef struct packed {
        logic [31:0]                          inst;
        logic [IQ_ID_W-1:0]                   id;
        logic [NUM_OPS-1:0]                   used;
        logic [NUM_OPS-1:0]                   rdy;
        logic [NUM_OPS-1:0][IQ_PRN_W-1:0]     src_prn;
        logic [NUM_OPS-1:0][63:0]             src_data;
        logic [NUM_OPS-1:0][IQ_PRN_W-1:0]     dst_prn;
        logic [NUM_OPS-1:0]                   dst_valid;
    } iq_entry_t;

    // Every operand is either not needed or already holds its value.
    function automatic logic entry_ready(input iq_entry_t e);
        return &(~e.used | e.rdy);
    endfunction

endpackage : fu_pkg
`default_nettype wire

// File: rtl/iq_age_select.sv
`default_nettype none
// ============================================================================
//  Module   : iq_age_select
//  Purpose  : Age matrix tracking dispatch order of queue slots, plus a
//             one-hot grant of the oldest slot whose ready bit is set.
//  Revision : 1.0 - initial release
// ============================================================================
module iq_age_select #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant
);

    // r_older[i][j] = 1 means slot j was dispatched before slot i.
    logic [DEPTH-1:0] r_older [DEPTH];
    logic [DEPTH-1:0] r_valid;

    // New slot becomes younger than every live slot; freed slots drop out of rows and columns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            r_valid <= (r_valid & ~free) | alloc;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc[i]) begin
                    r_older[i] <= r_valid & ~free;
                end else if (free[i]) begin
                    r_older[i] <= '0;
                end else begin
                    r_older[i] <= r_older[i] & ~free;
                end
            end
        end
    end

    // A ready slot wins when no older slot is also ready.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
            assign grant[gi] = ready[gi] & ~|(r_older[gi] & ready);
        end
    endgenerate

endmodule : iq_age_select
`default_nettype wire

// File: rtl/fu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fu_issue_queue
//  Purpose  : Reservation station for one functional unit. Holds dispatched
//             instructions, captures operands from the writeback broadcast
//             and issues the oldest fully-ready entry when the FU is ready.
//  Revision : 1.0 - initial release
// ============================================================================
module fu_issue_queue
    import fu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PRN_W = IQ_PRN_W,
    parameter int ID_W  = IQ_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [31:0]         disp_inst,
    input  logic [ID_W-1:0]     disp_id,
    input  logic [NUM_OPS-1:0]  disp_src_used,
    input  logic [NUM_OPS-1:0]  disp_src_rdy,
    input  logic [PRN_W-1:0]    disp_src_prn  [NUM_OPS],
    input  logic [63:0]         disp_src_data [NUM_OPS],
    input  logic [PRN_W-1:0]    disp_dst_prn  [NUM_OPS],
    input  logic [NUM_OPS-1:0]  disp_dst_valid,
    input  logic                wb_valid,
    input  logic [PRN_W-1:0]    wb_prn  [NUM_WB],
    input  logic [63:0]         wb_data [NUM_WB],
    input  logic [NUM_WB-1:0]   wb_data_valid,
    input  logic                fu_ready,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [ID_W-1:0]     inst_id,
    output logic [63:0]         op [NUM_OPS],
    output logic [PRN_W-1:0]    out_prn [NUM_OPS],
    output logic [NUM_OPS-1:0]  out_prn_valid
);

    iq_entry_t          r_entry [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    iq_entry_t          w_disp_entry;
    iq_entry_t          w_disp_woken;
    iq_entry_t          w_woken [DEPTH];
    iq_entry_t          w_sel;
    logic [DEPTH-1:0]   w_ready;
    logic [DEPTH-1:0]   w_alloc;
    logic [DEPTH-1:0]   w_grant;
    logic [DEPTH-1:0]   w_issue;
    logic [DEPTH-1:0]   w_free;
    logic               w_found;

    logic               r_inst_valid;
    logic [31:0]        r_inst;
    logic [ID_W-1:0]    r_inst_id;
    logic [63:0]        r_op [NUM_OPS];
    logic [PRN_W-1:0]   r_out_prn [NUM_OPS];
    logic [NUM_OPS-1:0] r_out_prn_valid;

    // Capture broadcast values into waiting operands; lanes are scanned high to
    // low so the lowest matching lane is the one that sticks.
    function automatic iq_entry_t wake(input iq_entry_t e);
        iq_entry_t r;
        logic      hit;
        r = e;
        for (int k = 0; k < NUM_OPS; k++) begin
            hit = 1'b0;
            if (wb_valid && r.used[k] && !r.rdy[k]) begin
                for (int j = NUM_WB - 1; j >= 0; j--) begin
                    if (wb_data_valid[j] && (IQ_PRN_W'(wb_prn[j]) == r.src_prn[k])) begin
                        r.src_data[k] = wb_data[j];
                        hit           = 1'b1;
                    end
                end
            end
            if (hit) begin
                r.rdy[k] = 1'b1;
            end
        end
        return r;
    endfunction

    assign disp_ready = ~&r_valid;
    assign w_issue    = (fu_ready && !flush) ? w_grant : '0;
    assign w_free     = flush ? '1 : w_issue;

    // Build the incoming entry, wake every slot, pick the lowest free slot and mux the granted payload.
    always_comb begin
        w_disp_entry           = '0;
        w_disp_entry.inst      = disp_inst;
        w_disp_entry.id        = IQ_ID_W'(disp_id);
        w_disp_entry.used      = disp_src_used;
        w_disp_entry.rdy       = disp_src_rdy;
        w_disp_entry.dst_valid = disp_dst_valid;
        for (int k = 0; k < NUM_OPS; k++) begin
            w_disp_entry.src_prn[k]  = IQ_PRN_W'(disp_src_prn[k]);
            w_disp_entry.src_data[k] = disp_src_data[k];
            w_disp_entry.dst_prn[k]  = IQ_PRN_W'(disp_dst_prn[k]);
        end
        w_disp_woken = wake(w_disp_entry);

        w_sel   = '0;
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = wake(r_entry[i]);
            w_ready[i] = r_valid[i] & entry_ready(r_entry[i]);
            if (w_grant[i]) begin
                w_sel = r_entry[i];
            end
            if (!r_valid[i] && !w_found) begin
                w_alloc[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        if (!disp_valid || flush) begin
            w_alloc = '0;
        end
    end

    iq_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .clk   (clk),
        .rst   (rst),
        .alloc (w_alloc),
        .free  (w_free),
        .ready (w_ready),
        .grant (w_grant)
    );

    // Slot occupancy: dispatch fills, issue frees, flush or reset empties all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~w_issue) | w_alloc;
        end
    end

    // Slot payload; meaningful only while the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= w_alloc[i] ? w_disp_woken : w_woken[i];
        end
    end

    // Issue register toward the FU; payload holds between issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_valid    <= 1'b0;
            r_inst          <= '0;
            r_inst_id       <= '0;
            r_out_prn_valid <= '0;
            for (int k = 0; k < NUM_OPS; k++) begin
                r_op[k]      <= '0;
                r_out_prn[k] <= '0;
            end
        end else if (flush) begin
            r_inst_valid <= 1'b0;
        end else begin
            r_inst_valid <= |w_issue;
            if (|w_issue) begin
                r_inst          <= w_sel.inst;
                r_inst_id       <= ID_W'(w_sel.id);
                r_out_prn_valid <= w_sel.dst_valid;
                for (int k = 0; k < NUM_OPS; k++) begin
                    r_op[k]      <= w_sel.used[k] ? w_sel.src_data[k] : 64'd0;
                    r_out_prn[k] <= PRN_W'(w_sel.dst_prn[k]);
                end
            end
        end
    end

    assign inst_valid    = r_inst_valid;
    assign inst          = r_inst;
    assign inst_id       = r_inst_id;
    assign op            = r_op;
    assign out_prn       = r_out_prn;
    assign out_prn_valid = r_out_prn_valid;

endmodule : fu_issue_queue
`default_nettype wire

// File: tb/tb_fu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fu_issue_queue
//  Purpose  : Self-checking bench for fu_issue_queue: vector table for single
//             instructions plus hand-written age, back-pressure, flush and
//             reset sequences, with a scoreboard of expected issues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fu_issue_queue;
    import fu_pkg::*;

    localparam int DEPTH = 4;
    localparam int PRN_W = 7;
    localparam int ID_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              disp_valid = 1'b0;
    logic              disp_ready;
    logic [31:0]       disp_inst = '0;
    logic [ID_W-1:0]   disp_id = '0;
    logic [2:0]        disp_src_used = '0;
    logic [2:0]        disp_src_rdy = '0;
    logic [PRN_W-1:0]  disp_src_prn [3];
    logic [63:0]       disp_src_data [3];
    logic [PRN_W-1:0]  disp_dst_prn [3];
    logic [2:0]        disp_dst_valid = '0;
    logic              wb_valid = 1'b0;
    logic [PRN_W-1:0]  wb_prn [3];
    logic [63:0]       wb_data [3];
    logic [2:0]        wb_data_valid = '0;
    logic              fu_ready = 1'b0;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [ID_W-1:0]   inst_id;
    logic [63:0]       op [3];
    logic [PRN_W-1:0]  out_prn [3];
    logic [2:0]        out_prn_valid;

    fu_issue_queue #(
        .DEPTH (DEPTH),
        .PRN_W (PRN_W),
        .ID_W  (ID_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_inst      (disp_inst),
        .disp_id        (disp_id),
        .disp_src_used  (disp_src_used),
        .disp_src_rdy   (disp_src_rdy),
        .disp_src_prn   (disp_src_prn),
        .disp_src_data  (disp_src_data),
        .disp_dst_prn   (disp_dst_prn),
        .disp_dst_valid (disp_dst_valid),
        .wb_valid       (wb_valid),
        .wb_prn         (wb_prn),
        .wb_data        (wb_data),
        .wb_data_valid  (wb_data_valid),
        .fu_ready       (fu_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_id        (inst_id),
        .op             (op),
        .out_prn        (out_prn),
        .out_prn_valid  (out_prn_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       inst;
        logic [5:0]        id;
        logic [2:0][63:0]  op;
        logic [2:0][6:0]   prn;
        logic [2:0]        prnv;
    } exp_t;

    typedef struct packed {
        logic [31:0]       inst;
        logic [5:0]        id;
        logic [2:0]        used;
        logic [2:0]        rdy;
        logic [2:0][6:0]   prn;
        logic [2:0][63:0]  data;
        logic [2:0][63:0]  wbd;
        logic [2:0][6:0]   dst;
        logic [2:0]        dstv;
        logic [2:0][63:0]  exp_op;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [5];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic [5:0] id, input logic [2:0][63:0] o,
                        input logic [2:0][6:0] dst, input logic [2:0] dstv);
        exp_t e;
        e.inst = ins; e.id = id; e.op = o; e.prn = dst; e.prnv = dstv;
        sb.push_back(e);
    endtask

    // Drive one dispatch for a single cycle; expects it to be accepted.
    task automatic dispatch(input logic [31:0] ins, input logic [5:0] id, input logic [2:0] used,
                            input logic [2:0] rdy, input logic [2:0][6:0] prn,
                            input logic [2:0][63:0] data, input logic [2:0][6:0] dst,
                            input logic [2:0] dstv);
        chk("disp_ready_at_dispatch", disp_ready, 1);
        disp_valid = 1'b1; disp_inst = ins; disp_id = id;
        disp_src_used = used; disp_src_rdy = rdy; disp_dst_valid = dstv;
        for (int k = 0; k < 3; k++) begin
            disp_src_prn[k]  = prn[k];
            disp_src_data[k] = data[k];
            disp_dst_prn[k]  = dst[k];
        end
        @(negedge clk);
        disp_valid = 1'b0;
    endtask

    task automatic bcast(input logic [2:0] dv, input logic [2:0][6:0] p, input logic [2:0][63:0] d);
        wb_valid = 1'b1; wb_data_valid = dv;
        for (int j = 0; j < 3; j++) begin
            wb_prn[j]  = p[j];
            wb_data[j] = d[j];
        end
    endtask

    task automatic wb_idle();
        wb_valid = 1'b0; wb_data_valid = '0;
    endtask

    // Scoreboard: every issue must match the next expected instruction.
    always @(negedge clk) begin
        exp_t e;
        if (rst && inst_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got id %0d inst 0x%0h, expected no issue", inst_id, inst);
            end else begin
                e = sb.pop_front();
                chk("issue_inst", inst, e.inst);
                chk("issue_id", inst_id, e.id);
                for (int k = 0; k < 3; k++) begin
                    chk("issue_op", op[k], e.op[k]);
                    chk("issue_out_prn", out_prn[k], e.prn[k]);
                end
                chk("issue_out_prn_valid", out_prn_valid, e.prnv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            disp_src_prn[k] = '0; disp_src_data[k] = '0; disp_dst_prn[k] = '0;
            wb_prn[k] = '0; wb_data[k] = '0;
        end
        // data order in concatenations is {op2, op1, op0}
        vecs[0] = '{inst:32'h00B5_0533, id:6'd1, used:3'b001, rdy:3'b001, prn:'0,
                    data:{64'hDEAD, 64'hBEEF, 64'h10}, wbd:'0,
                    dst:{7'd0, 7'd0, 7'd5}, dstv:3'b001, exp_op:{64'h0, 64'h0, 64'h10}};
        vecs[1] = '{inst:32'h1234_5678, id:6'd2, used:3'b111, rdy:3'b111, prn:'0,
                    data:{64'h3, 64'h2, 64'h1}, wbd:'0,
                    dst:{7'd9, 7'd8, 7'd7}, dstv:3'b101, exp_op:{64'h3, 64'h2, 64'h1}};
        vecs[2] = '{inst:32'hCAFE_0001, id:6'd3, used:3'b011, rdy:3'b001, prn:{7'd0, 7'd22, 7'd0},
                    data:{64'h0, 64'h5555, 64'h44}, wbd:{64'h0, 64'h77, 64'h0},
                    dst:{7'd0, 7'd0, 7'd3}, dstv:3'b001, exp_op:{64'h0, 64'h77, 64'h44}};
        vecs[3] = '{inst:32'hCAFE_0002, id:6'd4, used:3'b101, rdy:3'b000, prn:{7'd25, 7'd0, 7'd24},
                    data:'0, wbd:{64'hAA, 64'h0, 64'hBB},
                    dst:'0, dstv:3'b000, exp_op:{64'hAA, 64'h0, 64'hBB}};
        vecs[4] = '{inst:32'hCAFE_0003, id:6'd5, used:3'b010, rdy:3'b010, prn:'0,
                    data:{64'h9, 64'h1234, 64'h9}, wbd:'0,
                    dst:{7'd1, 7'd2, 7'd3}, dstv:3'b111, exp_op:{64'h0, 64'h1234, 64'h0}};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_inst_valid", inst_valid, 0);
        chk("reset_inst", inst, 0);
        chk("reset_inst_id", inst_id, 0);
        chk("reset_op0", op[0], 0);
        chk("reset_out_prn0", out_prn[0], 0);
        chk("reset_out_prn_valid", out_prn_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_disp_ready", disp_ready, 1);
        fu_ready = 1'b1;

        // Table of single-instruction vectors
        for (int n = 0; n < 5; n++) begin
            push(vecs[n].inst, vecs[n].id, vecs[n].exp_op, vecs[n].dst, vecs[n].dstv);
            dispatch(vecs[n].inst, vecs[n].id, vecs[n].used, vecs[n].rdy, vecs[n].prn,
                     vecs[n].data, vecs[n].dst, vecs[n].dstv);
            if ((vecs[n].used & ~vecs[n].rdy) != 3'b000) begin
                chk("vec_wait_no_issue", inst_valid, 0);
                bcast(vecs[n].used & ~vecs[n].rdy, vecs[n].prn, vecs[n].wbd);
                @(negedge clk);
                wb_idle();
            end
            chk("vec_not_early", inst_valid, 0);
            @(negedge clk);
            chk("vec_issue", inst_valid, 1);
            @(negedge clk);
            chk("vec_drained", sb.size(), 0);
        end

        // Wakeup: SUBS waits on prn 12 (op0) and prn 13 (op1)
        push(32'h6B0D_0000, 6'd7, {64'h0, 64'h3, 64'h7}, {7'd0, 7'd0, 7'd6}, 3'b001);
        dispatch(32'h6B0D_0000, 6'd7, 3'b011, 3'b000, {7'd0, 7'd13, 7'd12}, '0, {7'd0, 7'd0, 7'd6}, 3'b001);
        bcast(3'b010, {7'd0, 7'd12, 7'd12}, {64'h0, 64'h7, 64'h55});
        @(negedge clk);
        wb_idle();
        chk("wake_partial_no_issue", inst_valid, 0);
        @(negedge clk);
        chk("wake_partial_no_issue2", inst_valid, 0);
        bcast(3'b110, {7'd13, 7'd13, 7'd13}, {64'd99, 64'h3, 64'h55});
        @(negedge clk);
        wb_idle();
        chk("wake_edge_no_issue", inst_valid, 0);
        @(negedge clk);
        chk("wake_issue", inst_valid, 1);

        // Same-cycle dispatch and broadcast
        push(32'h0000_0ABC, 6'd8, {64'h0, 64'h0, 64'hABC}, '0, 3'b000);
        bcast(3'b100, {7'd40, 7'd0, 7'd0}, {64'hABC, 64'h0, 64'h0});
        dispatch(32'h0000_0ABC, 6'd8, 3'b001, 3'b000, {7'd0, 7'd0, 7'd40}, '0, '0, 3'b000);
        wb_idle();
        chk("same_cycle_no_issue", inst_valid, 0);
        @(negedge clk);
        chk("same_cycle_issue", inst_valid, 1);
        @(negedge clk);

        // Age order: entries 2 and 0 wake together, 2 was dispatched first
        fu_ready = 1'b0;
        dispatch(32'hA, 6'd10, 3'b001, 3'b001, '0, {64'h0, 64'h0, 64'hA0}, '0, 3'b000);
        dispatch(32'hB, 6'd11, 3'b001, 3'b000, {7'd0, 7'd0, 7'd20}, '0, '0, 3'b000);
        dispatch(32'hC, 6'd12, 3'b001, 3'b000, {7'd0, 7'd0, 7'd21}, '0, '0, 3'b000);
        push(32'hA, 6'd10, {64'h0, 64'h0, 64'hA0}, '0, 3'b000);
        fu_ready = 1'b1;
        @(negedge clk);
        chk("age_first_issue", inst_valid, 1);
        dispatch(32'hD, 6'd13, 3'b001, 3'b000, {7'd0, 7'd0, 7'd21}, '0, '0, 3'b000);
        dispatch(32'hE, 6'd14, 3'b001, 3'b000, {7'd0, 7'd0, 7'd22}, '0, '0, 3'b000);
        chk("age_full", disp_ready, 0);
        push(32'hC, 6'd12, {64'h0, 64'h0, 64'h121}, '0, 3'b000);
        push(32'hD, 6'd13, {64'h0, 64'h0, 64'h121}, '0, 3'b000);
        bcast(3'b001, {7'd0, 7'd0, 7'd21}, {64'h0, 64'h0, 64'h121});
        @(negedge clk);
        wb_idle();
        @(negedge clk);
        chk("age_c_issue", inst_valid, 1);
        @(negedge clk);
        chk("age_d_issue", inst_valid, 1);
        push(32'hB, 6'd11, {64'h0, 64'h0, 64'h200}, '0, 3'b000);
        push(32'hE, 6'd14, {64'h0, 64'h0, 64'h222}, '0, 3'b000);
        bcast(3'b011, {7'd0, 7'd22, 7'd20}, {64'h0, 64'h222, 64'h200});
        @(negedge clk);
        wb_idle();
        repeat (3) @(negedge clk);
        chk("age_drained", sb.size(), 0);

        // Back-pressure and full
        fu_ready = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            push(32'h100 + n, 6'(20 + n), {64'h0, 64'h0, 64'(n + 1)}, {7'd0, 7'd0, 7'(n)}, 3'b001);
            dispatch(32'h100 + n, 6'(20 + n), 3'b001, 3'b001, '0, {64'h0, 64'h0, 64'(n + 1)},
                     {7'd0, 7'd0, 7'(n)}, 3'b001);
        end
        chk("full_disp_ready", disp_ready, 0);
        chk("backpressure_no_issue", inst_valid, 0);
        @(negedge clk);
        chk("backpressure_still_no_issue", inst_valid, 0);
        fu_ready = 1'b1;
        disp_valid = 1'b1; disp_inst = 32'h999; disp_id = 6'd30;
        disp_src_used = 3'b000; disp_src_rdy = 3'b000; disp_dst_valid = 3'b000;
        @(negedge clk);
        disp_valid = 1'b0;
        chk("burst_issue0", inst_valid, 1);
        chk("freed_slot_disp_ready", disp_ready, 1);
        for (int n = 1; n < DEPTH; n++) begin
            @(negedge clk);
            chk("burst_issue", inst_valid, 1);
        end
        @(negedge clk);
        chk("burst_end", inst_valid, 0);
        repeat (2) @(negedge clk);
        chk("full_drained", sb.size(), 0);

        // Flush with one entry selected at the flush edge
        fu_ready = 1'b0;
        dispatch(32'hF0, 6'd40, 3'b001, 3'b001, '0, {64'h0, 64'h0, 64'h1}, '0, 3'b000);
        dispatch(32'hF1, 6'd41, 3'b001, 3'b000, {7'd0, 7'd0, 7'd30}, '0, '0, 3'b000);
        dispatch(32'hF2, 6'd42, 3'b001, 3'b000, {7'd0, 7'd0, 7'd31}, '0, '0, 3'b000);
        fu_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_no_issue", inst_valid, 0);
        chk("flush_disp_ready", disp_ready, 1);
        bcast(3'b011, {7'd0, 7'd31, 7'd30}, {64'h0, 64'h5, 64'h6});
        @(negedge clk);
        wb_idle();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("flush_stale_no_issue", inst_valid, 0);
        end

        // Reset mid-run with three entries held
        fu_ready = 1'b0;
        dispatch(32'h50, 6'd50, 3'b001, 3'b001, '0, {64'h0, 64'h0, 64'h50}, '0, 3'b000);
        dispatch(32'h51, 6'd51, 3'b001, 3'b000, {7'd0, 7'd0, 7'd51}, '0, '0, 3'b000);
        dispatch(32'h52, 6'd52, 3'b001, 3'b000, {7'd0, 7'd0, 7'd52}, '0, '0, 3'b000);
        chk("pre_reset_disp_ready", disp_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_inst_valid", inst_valid, 0);
        rst = 1'b1;
        chk("post_reset_disp_ready", disp_ready, 1);
        fu_ready = 1'b1;
        bcast(3'b011, {7'd0, 7'd52, 7'd51}, {64'h0, 64'h1, 64'h2});
        @(negedge clk);
        wb_idle();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("post_reset_no_issue", inst_valid, 0);
        end
        push(32'h60, 6'd60, {64'h0, 64'h0, 64'h61}, {7'd0, 7'd0, 7'd9}, 3'b001);
        dispatch(32'h60, 6'd60, 3'b001, 3'b001, '0, {64'h0, 64'h0, 64'h61}, {7'd0, 7'd0, 7'd9}, 3'b001);
        chk("post_reset_not_early", inst_valid, 0);
        @(negedge clk);
        chk("post_reset_issue", inst_valid, 1);
        repeat (2) @(negedge clk);
        chk("final_scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fu_issue_queue
`default_nettype wire

// File: doc/fu_issue_queue.md
# fu_issue_queue

Reservation station feeding one functional unit over the FU issue interface: the producer side of the `inst`/`op`/`inst_valid` handshake that arithmetic-style FUs consume. It holds dispatched instructions and captures operand values from the writeback broadcast as they are produced. Each cycle it issues the oldest fully-ready entry to the FU when the FU reports `fu_ready`. One instance sits between rename/dispatch and each FU.

## Interface
- `DEPTH`, 4: number of entries, 2..16.
- `PRN_W`, 7: physical register tag width.
- `ID_W`, 6: instruction id width.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `flush`  in  1  synchronous; drops all entries.
- `disp_valid` / `disp_ready`  in/out  1/1  dispatch handshake; transfer when both are high.
- `disp_inst`  in  32  instruction word.
- `disp_id`  in  ID_W  instruction id.
- `disp_src_used[3]`  in  1 each  operand k is needed.
- `disp_src_rdy[3]`  in  1 each  operand k value already known.
- `disp_src_prn[3]`  in  PRN_W each  source tag.
- `disp_src_data[3]`  in  64 each  value, valid when rdy.
- `disp_dst_prn[3]` / `disp_dst_valid[3]`  in  PRN_W / 1 each  destination tags.
- `wb_valid`  in  1  writeback broadcast this cycle.
- `wb_prn[3]` / `wb_data[3]` / `wb_data_valid[3]`  in  PRN_W / 64 / 1 each  broadcast results (FU output format).
- `fu_ready`  in  1  FU can accept an instruction this cycle.
- `inst_valid`  out  1  issue strobe; one cycle per issued instruction.
- `inst`  out  32  issued instruction word.
- `inst_id`  out  ID_W  issued id.
- `op[3]`  out  64 each  operand values; 0 for unused operands.
- `out_prn[3]` / `out_prn_valid[3]`  out  PRN_W / 1 each  destination tags passed to the FU.

## Operation
- Entry state: valid, instruction payload, and per operand {used, rdy, prn, data}. An entry is ready when valid and, for every k, (!used[k] | rdy[k]).
- Dispatch: `disp_ready` = any entry free (combinational from registered state). A transfer writes the lowest-index free entry.
- Wakeup: for each valid entry, each operand k with used & !rdy, and each j: if `wb_valid & wb_data_valid[j] & wb_prn[j]==src_prn[k]`, capture `wb_data[j]` and set rdy.
  - Wakeup also applies to the operands of an instruction being dispatched in the same cycle, so a broadcast is never missed.
  - If several j match, the lowest j wins.
- Select: at an edge where `fu_ready`=1 and at least one entry is ready, choose the oldest ready entry by dispatch order (age matrix).
  - Register its payload onto the outputs and assert `inst_valid` for the following cycle.
  - Free the entry at the same edge.
- Age: an age matrix bit older[i][j] is set on dispatch of i against every valid j and cleared when the entry frees. No wrap-around issue exists.
- Selection uses the ready state before the edge. An operand woken at edge E makes its entry selectable at edge E+1.
- `flush` takes priority over dispatch, wakeup and issue: all entries invalid and `inst_valid`=0 after the edge.
- A dispatch attempted while `disp_ready`=0 is ignored. A freed slot becomes visible on `disp_ready` the cycle after the issue edge (no same-cycle credit).

## Timing
- Reset values: all entries invalid; `inst_valid`=0; `inst`, `inst_id`, `op`, `out_prn`, `out_prn_valid`=0; `disp_ready`=1 once reset deasserts. Reset asserted mid-operation discards everything immediately.
- Minimum latency: dispatch with all operands ready at edge E0 → issued at edge E1 → `inst_valid` high in cycle E1..E2.
- Wakeup-to-issue: broadcast captured at edge E → earliest issue at edge E+1.
- Throughput: one issue per cycle while `fu_ready`=1 and ready entries exist. Back-to-back `inst_valid` is allowed.
- `fu_ready`=0: no issue, `inst_valid`=0 next cycle, entries retained.
- Full: `disp_ready`=0 with DEPTH valid entries. Simultaneous issue plus dispatch attempt in that cycle does not accept the dispatch.

## Structure
- Shared package `fu_pkg`: `NUM_OPS`=3, PRN/ID width constants, typedef `iq_entry_t` (payload plus per-operand {used, rdy, prn, data}).
- Sub-module `iq_age_select`: age matrix plus oldest-ready one-hot select, parameterised by DEPTH. Inputs: alloc one-hot, free one-hot, ready vector. Output: grant one-hot.

## Test plan
- Reset/idle: assert `rst`=0 mid-run with 3 entries valid → after release `disp_ready`=1, `inst_valid`=0, a new ready dispatch issues at the first edge after acceptance.
- Ready-at-dispatch: dispatch ADD with op0 rdy = 0x10, op1/op2 unused, dst prn 5 → `inst_valid` one cycle later with op[0]=0x10, op[1]=op[2]=0, out_prn[0]=5.
- Wakeup: dispatch SUBS waiting on prn 12 and prn 13. Broadcast prn 12=7 at E, then prn 13=3 at E+2 → issue at edge E+3, op[0]=7, op[1]=3. Also check a same-cycle dispatch/broadcast match is captured.
- Age order: fill 4 entries, make entries 2 and 0 (dispatched in that order) ready in the same cycle → entry 2 issues first, entry 0 next cycle.
- Back-pressure/full: hold `fu_ready`=0 with DEPTH ready entries → `disp_ready`=0, no `inst_valid`. Raise `fu_ready` → DEPTH consecutive issues, `disp_ready`=1 the cycle after the first issue.
- Flush: flush with 3 entries, one selected that edge → no `inst_valid` afterwards, `disp_ready`=1, stale wakeups ignored.
